speed_tick_divider: RTL and testbench
=====================================

Name: speed_tick_divider

Overview:
- Parametrised successor to the single-rate game clock divider.
- Generates a 50%-duty game clock (divided_clk) and a one-cycle tick strobe from clk_in (40 MHz).
- Half-period shrinks by a programmable step per speed level, clamped at a floor.
- Level changes are applied glitch-free, only at toggle boundaries. Feeds the ball-motion and paddle logic.

Parameters:
- CNT_W, 26, width of the half-period counter and all period arithmetic.
- LEVEL_W, 3, width of the speed-level input.
- BASE_HALF, 20_000_000, half-period in clk_in cycles at level 0 (1 Hz at 40 MHz).
- STEP_HALF, 2_000_000, half-period reduction per level.
- MIN_HALF, 4_000_000, floor on the half-period; requires 1 <= MIN_HALF <= BASE_HALF < 2**CNT_W.
- RAMP_HALF, 1_000_000, max half-period change per toggle (used only with the optional feature).

Ports:
- clk_in  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable; low freezes counter and outputs.
- level  in  LEVEL_W  requested speed level (hit count).
- level_load  in  1  strobe: capture level into the pending register.
- divided_clk  out  1  game clock, toggles every active half-period.
- tick  out  1  one clk_in pulse coincident with each 0->1 transition of divided_clk.
- half_active  out  CNT_W  half-period currently in force.
- running  out  1  high in RUN state.

Behaviour:
- Reset values: divided_clk=0, tick=0, running=0, cnt=0, pending level=0, half_active=BASE_HALF. FSM=IDLE.
- Target computation, combinational from the pending level:
  - prod = level_p*STEP_HALF, computed at CNT_W+LEVEL_W bits with no truncation.
  - If prod >= BASE_HALF-MIN_HALF, target=MIN_HALF; else target=BASE_HALF-prod.
  - No wrap-around for any level value.
- FSM IDLE:
  - Counter held at 0; outputs hold their values; running=0.
  - en=1 -> RUN on the next edge.
- FSM RUN:
  - running=1.
  - cnt increments each cycle.
  - When cnt >= half_active-1:
    - cnt<=0, divided_clk toggles, and half_active<=target in the same edge.
    - tick=1 for that one cycle if divided_clk goes 0->1.
  - The >= comparison guarantees a toggle even if half_active ever drops below cnt.
  - en=0 -> PAUSE.
- FSM PAUSE:
  - cnt, divided_clk and half_active frozen; tick=0; running=0.
  - en=1 -> RUN; counting resumes from the frozen cnt, so no period is lost or restarted.
- level_load:
  - Registers level into level_p on the next edge in any state.
  - Takes effect at the next toggle, never mid half-period.
  - Multiple loads within one half-period: last value wins.
  - A load in the same cycle as a toggle is not used by that toggle; it applies at the following toggle.
- Timing from reset release with en=1:
  - First rising edge of divided_clk at clk_in cycle BASE_HALF+1 (one cycle IDLE->RUN, then BASE_HALF counts).
  - tick is asserted in the same cycle divided_clk reads 1.
- Reset mid-operation returns all state to reset values immediately, asynchronously.

Optional Feature:
- Macro SPEED_DIV_RAMP_EN.
- Defined: at each toggle, half_active moves toward target by at most RAMP_HALF (saturating, no overshoot), giving gradual speed-up and slow-down.
- Undefined: half_active jumps directly to target at the next toggle; RAMP_HALF is unused.

Decomposition:
- Package game_timing_pkg holds:
  - Constants CLK_HZ=40_000_000 and the BASE/STEP/MIN/RAMP defaults.
  - The state enum typedef {IDLE, RUN, PAUSE}.
- One combinational sub-module, speed_period_calc: level_p -> clamped target. Reusable by the score-display blink timer.
- Counter, FSM and ramp logic stay in the top module.

Test Plan (BASE_HALF=10, STEP_HALF=2, MIN_HALF=3, RAMP_HALF=2, CNT_W=8):
- Reset, en=1, level 0 -> divided_clk rises at cycle 11, then period 20; tick high exactly 1 cycle per 20; half_active=10.
- level_load with level=3 mid half-period -> current half finishes at 10; the next half-periods are 4; half_active=4.
- level=7 (prod 14 exceeds BASE_HALF-MIN_HALF=7) -> half_active clamps to 3, no wrap; level=4 also gives 3.
- en=0 at cnt=5 for 7 cycles, then en=1 -> divided_clk frozen, running=0, tick=0; the toggle occurs 5 enabled cycles after resume.
- rst pulse mid-period at level 3 -> immediately divided_clk=0, half_active=10, running=0; the restart timing matches the first scenario.
- With SPEED_DIV_RAMP_EN defined, load level 4 from 0 -> half_active sequence 10, 8, 6, 4, 3 on successive toggles.

Source files
------------

// File: rtl/speed_tick_divider_pkg.sv
// Shared game-timing constants and the divider state type.
// Consumed by speed_tick_divider and speed_period_calc.
package game_timing_pkg;

  localparam int CLK_HZ        = 40_000_000;
  localparam int BASE_HALF_DEF = 20_000_000;
  localparam int STEP_HALF_DEF = 2_000_000;
  localparam int MIN_HALF_DEF  = 4_000_000;
  localparam int RAMP_HALF_DEF = 1_000_000;
  localparam int CNT_W_DEF     = 26;
  localparam int LEVEL_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } div_state_e;

endpackage

// File: rtl/speed_tick_divider_speed_period_calc.sv
// Maps a speed level to its half-period: BASE - level*STEP, clamped at MIN.
// Purely combinational; the product is kept at full width so no level can wrap.
module speed_period_calc
  import game_timing_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int LEVEL_W   = LEVEL_W_DEF,
  parameter int BASE_HALF = BASE_HALF_DEF,
  parameter int STEP_HALF = STEP_HALF_DEF,
  parameter int MIN_HALF  = MIN_HALF_DEF
) (
  input  logic [LEVEL_W-1:0] level_p_i,
  output logic [CNT_W-1:0]   target_o
);

  localparam int PW = CNT_W + LEVEL_W;
  localparam logic [PW-1:0]    STEP_P = PW'(STEP_HALF);
  localparam logic [PW-1:0]    SPAN_P = PW'(BASE_HALF - MIN_HALF);
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_HALF);

  logic [PW-1:0] prod_s;

  // Below the span the product fits in CNT_W bits, so the narrow subtract is exact.
  always_comb begin
    prod_s = PW'(level_p_i) * STEP_P;
    if (prod_s >= SPAN_P) begin
      target_o = MIN_C;
    end else begin
      target_o = BASE_C - prod_s[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/speed_tick_divider.sv
// Variable-rate game clock divider with tick strobe and glitch-free level changes.
// Optional macro SPEED_DIV_RAMP_EN: limit each half-period change to RAMP_HALF.
module speed_tick_divider
  import game_timing_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int LEVEL_W   = LEVEL_W_DEF,
  parameter int BASE_HALF = BASE_HALF_DEF,
  parameter int STEP_HALF = STEP_HALF_DEF,
  parameter int MIN_HALF  = MIN_HALF_DEF,
  parameter int RAMP_HALF = RAMP_HALF_DEF
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_load,
  output logic               divided_clk,
  output logic               tick,
  output logic [CNT_W-1:0]   half_active,
  output logic               running
);

  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0] RAMP_C = CNT_W'(RAMP_HALF);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
`ifdef SPEED_DIV_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   half_q;
  logic [LEVEL_W-1:0] level_p_q;
  logic               div_q;
  logic               tick_q;
  logic               running_q;

  logic [CNT_W-1:0]   target_s;
  logic [CNT_W-1:0]   ramp_s;
  logic [CNT_W-1:0]   half_d;
  logic               wrap_s;

  speed_period_calc #(
    .CNT_W    (CNT_W),
    .LEVEL_W  (LEVEL_W),
    .BASE_HALF(BASE_HALF),
    .STEP_HALF(STEP_HALF),
    .MIN_HALF (MIN_HALF)
  ) u_period_calc (
    .level_p_i(level_p_q),
    .target_o (target_s)
  );

  // Saturating move toward the target, never overshooting it.
  function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
    if (tgt > cur) begin
      return ((tgt - cur) > RAMP_C) ? (cur + RAMP_C) : tgt;
    end else begin
      return ((cur - tgt) > RAMP_C) ? (cur - RAMP_C) : tgt;
    end
  endfunction

  // Next half-period chosen at a toggle, plus the toggle condition itself.
  always_comb begin
    ramp_s = ramp_toward(half_q, target_s);
    if (RAMP_ON) begin
      half_d = ramp_s;
    end else begin
      half_d = target_s;
    end
    wrap_s = (cnt_q >= (half_q - ONE_C));
  end

  // Counter, state machine and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= BASE_C;
      level_p_q <= '0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (level_load) begin
        level_p_q <= level;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (en) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else begin
            running_q <= 1'b0;
          end
        end
        RUN, PAUSE: begin
          // A resuming edge counts immediately so the frozen half-period continues seamlessly.
          if (en) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            if (wrap_s) begin
              cnt_q  <= '0;
              div_q  <= ~div_q;
              tick_q <= ~div_q;
              half_q <= half_d;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
          end else begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign divided_clk = div_q;
  assign tick        = tick_q;
  assign half_active = half_q;
  assign running     = running_q;

endmodule

// File: tb/tb_speed_tick_divider.sv
// Self-checking bench for speed_tick_divider against a countdown reference model.
module tb_speed_tick_divider;

  localparam int CNT_W = 8;
  localparam int LEVEL_W = 3;
  localparam int BASE = 10;
  localparam int STEP = 2;
  localparam int MINH = 3;
  localparam int RAMP = 2;

  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [LEVEL_W-1:0] level = '0;
  logic level_load = 1'b0;
  logic divided_clk, tick, running;
  logic [CNT_W-1:0] half_active;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining enabled cycles in the current half-period.
  bit m_started, m_run, m_div, m_tick;
  int m_half, m_left, m_lvl;

  speed_tick_divider #(
    .CNT_W(CNT_W), .LEVEL_W(LEVEL_W), .BASE_HALF(BASE),
    .STEP_HALF(STEP), .MIN_HALF(MINH), .RAMP_HALF(RAMP)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .level(level), .level_load(level_load),
    .divided_clk(divided_clk), .tick(tick), .half_active(half_active), .running(running)
  );

  always #5 clk_in = ~clk_in;

  function automatic int target_of(input int lvl);
    int t;
    t = BASE - lvl * STEP;
    return (t < MINH) ? MINH : t;
  endfunction

  function automatic int next_half(input int cur, input int tgt);
`ifdef SPEED_DIV_RAMP_EN
    if (tgt - cur > RAMP) return cur + RAMP;
    if (cur - tgt > RAMP) return cur - RAMP;
    return tgt;
`else
    return tgt;
`endif
  endfunction

  task automatic model_reset();
    m_started = 0; m_run = 0; m_div = 0; m_tick = 0;
    m_half = BASE; m_left = BASE; m_lvl = 0;
  endtask

  // Advance model with the inputs present before the edge, then the clock.
  task automatic clk_step();
    m_tick = 0;
    if (!m_started) begin
      if (en) begin m_started = 1; m_run = 1; end
    end else if (en) begin
      m_run = 1;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_div = ~m_div;
        m_tick = m_div;
        m_half = next_half(m_half, target_of(m_lvl));
        m_left = m_half;
      end
    end else begin
      m_run = 0;
    end
    if (level_load) m_lvl = int'(level);
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; level_load = 1'b0; level = '0;
    apply_reset();
    checks++;
    if ({divided_clk, tick, running} !== 3'b000 || half_active !== 8'(BASE)) begin
      errors++;
      $display("FAIL reset: div=%0b tick=%0b run=%0b half=%0d required 0 0 0 %0d",
               divided_clk, tick, running, half_active, BASE);
    end
  endtask

  task automatic test_base_rate();
    int first_rise = 0;
    int ticks = 0;
    en = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      clk_step();
      if (divided_clk && first_rise == 0) first_rise = n;
      if (tick) ticks++;
      checks++;
      if (divided_clk !== m_div || tick !== m_tick || running !== m_run || half_active !== 8'(m_half)) begin
        errors++;
        $display("FAIL base_cycle%0d: div=%0b tick=%0b run=%0b half=%0d required %0b %0b %0b %0d",
                 n, divided_clk, tick, running, half_active, m_div, m_tick, m_run, m_half);
      end
    end
    checks++;
    if (first_rise != BASE + 1) begin
      errors++;
      $display("FAIL first_rise: cycle %0d required %0d", first_rise, BASE + 1);
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL tick_count: %0d required 3", ticks);
    end
  endtask

  task automatic load_and_run(input int lvl, input int cycles, input int want_half, input string nm);
    level = LEVEL_W'(lvl);
    level_load = 1'b1;
    clk_step();
    level_load = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      clk_step();
      checks++;
      if (divided_clk !== m_div || tick !== m_tick || half_active !== 8'(m_half)) begin
        errors++;
        $display("FAIL %s_cycle%0d: div=%0b tick=%0b half=%0d required %0b %0b %0d",
                 nm, n, divided_clk, tick, half_active, m_div, m_tick, m_half);
      end
    end
    checks++;
    if (half_active !== 8'(want_half)) begin
      errors++;
      $display("FAIL %s_half: %0d required %0d", nm, half_active, want_half);
    end
  endtask

  task automatic test_level_load();
    for (int n = 0; n < 4; n++) clk_step();
    load_and_run(3, 60, 4, "level3");
  endtask

  task automatic test_clamp();
    load_and_run(7, 40, 3, "level7");
    load_and_run(4, 40, 3, "level4");
  endtask

  task automatic test_pause();
    int guard = 0;
    int edges = 0;
    logic div_before;
    level = '0; level_load = 1'b1; clk_step(); level_load = 1'b0;
    while (!(m_half == BASE && m_left == BASE) && guard < 400) begin
      clk_step(); guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL pause_setup: timeout after %0d cycles", guard);
    end
    for (int n = 0; n < 5; n++) clk_step();
    div_before = divided_clk;
    en = 1'b0;
    for (int n = 0; n < 7; n++) begin
      clk_step();
      checks++;
      if (divided_clk !== div_before || running !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL pause_frozen%0d: div=%0b run=%0b tick=%0b required %0b 0 0",
                 n, divided_clk, running, tick, div_before);
      end
    end
    en = 1'b1;
    while (divided_clk === div_before && edges < 50) begin
      clk_step(); edges++;
    end
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL pause_resume: toggle after %0d cycles required 5", edges);
    end
  endtask

  task automatic test_reset_mid();
    int first_rise = 0;
    level = 3'd3; level_load = 1'b1; clk_step(); level_load = 1'b0;
    for (int n = 0; n < 37; n++) clk_step();
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    checks++;
    if (divided_clk !== 1'b0 || running !== 1'b0 || tick !== 1'b0 || half_active !== 8'(BASE)) begin
      errors++;
      $display("FAIL reset_mid: div=%0b run=%0b tick=%0b half=%0d required 0 0 0 %0d",
               divided_clk, running, tick, half_active, BASE);
    end
    model_reset();
    @(negedge clk_in);
    rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      clk_step();
      if (divided_clk && first_rise == 0) first_rise = n;
    end
    checks++;
    if (first_rise != BASE + 1) begin
      errors++;
      $display("FAIL restart_rise: cycle %0d required %0d", first_rise, BASE + 1);
    end
  endtask

  task automatic test_ramp();
    int seen[$];
`ifdef SPEED_DIV_RAMP_EN
    int exp_seq[5] = '{10, 8, 6, 4, 3};
`else
    int exp_seq[5] = '{10, 3, 3, 3, 3};
`endif
    en = 1'b0;
    apply_reset();
    en = 1'b1;
    level = 3'd4; level_load = 1'b1; clk_step(); level_load = 1'b0;
    seen.push_back(int'(half_active));
    for (int n = 0; n < 200 && seen.size() < 5; n++) begin
      logic d0;
      d0 = divided_clk;
      clk_step();
      if (divided_clk !== d0) seen.push_back(int'(half_active));
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= seen.size() || seen[i] != exp_seq[i]) begin
        errors++;
        $display("FAIL ramp_seq%0d: %0d required %0d", i, (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      level = LEVEL_W'($urandom_range(0, 7));
      level_load = ($urandom_range(0, 14) == 0);
      clk_step();
      checks++;
      if (divided_clk !== m_div || tick !== m_tick || running !== m_run || half_active !== 8'(m_half)) begin
        errors++;
        $display("FAIL random_cycle%0d: div=%0b tick=%0b run=%0b half=%0d required %0b %0b %0b %0d",
                 n, divided_clk, tick, running, half_active, m_div, m_tick, m_run, m_half);
      end
    end
    level_load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_base_rate();
    test_level_load();
    test_clamp();
    test_pause();
    test_reset_mid();
    test_ramp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
